// File: rtl/controlador_double_dabble.sv
// Binary-to-BCD converter (double dabble) with one shared add-3 corrector time-multiplexed over the digits.
// Latency: done pulses WIDTH*(DIGITS+1)+1 cycles after the start edge (33 cycles for 8/3); bcd updates on the edge entering FIN.
// Backpressure: none. start is only honoured in IDLE and ignored while busy or done. Optional macro: CONVERSOR_SINAL_EN (two's complement input).
module controlador_double_dabble #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binario,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  negativo
);

    localparam int KW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = 4*DIGITS + WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CORR, S_SHIFT, S_FIN} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [4*DIGITS-1:0]   r_digits;
    logic [WIDTH-1:0]      r_bin;
    logic [KW-1:0]         r_k;
    logic [DW-1:0]         r_d;
    logic [4*DIGITS-1:0]   r_bcd;

    logic                  w_last_digit;
    logic                  w_last_bit;
    logic [3:0]            w_nib;
    logic                  w_ge5;
    logic [3:0]            w_nib_corr;
    logic [TW-1:0]         w_shifted;
    logic [WIDTH-1:0]      w_bin_load;

    assign w_last_digit = (r_d == DW'(DIGITS-1));
    assign w_last_bit   = (r_k == KW'(WIDTH-1));

    // Shared corrector: the nibble selected by r_d gets +3 when it is 5 or more (carry cannot occur).
    assign w_nib      = r_digits[4*r_d +: 4];
    assign w_ge5      = w_nib[3] | (w_nib[2] & w_nib[1]) | (w_nib[2] & w_nib[0]);
    assign w_nib_corr = w_ge5 ? (w_nib + 4'd3) : w_nib;

    // The whole {digits,bin} word shifted left by one; bin MSB falls into digit 0 LSB.
    assign w_shifted = {r_digits, r_bin} << 1;

`ifdef CONVERSOR_SINAL_EN
    logic r_sign;
    logic r_neg;
    // Magnitude of a two's complement value; WIDTH-bit negation read as unsigned gives 2^(WIDTH-1) for the most negative input.
    assign w_bin_load = binario[WIDTH-1] ? (~binario + WIDTH'(1)) : binario;
    assign negativo   = r_neg;
`else
    assign w_bin_load = binario;
    assign negativo   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: DIGITS correction cycles then one shift, WIDTH times, then FIN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CORR;
            S_CORR:  if (w_last_digit) w_next = S_SHIFT;
            S_SHIFT: w_next = w_last_bit ? S_FIN : S_CORR;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: busy covers the working states, done is the single FIN cycle.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        bcd  = r_bcd;
        case (r_state)
            S_CORR, S_SHIFT: busy = 1'b1;
            S_FIN:           done = 1'b1;
            default:         ;
        endcase
    end

    // Datapath: capture, per-digit correction, shift, and result load on the last shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits <= '0;
            r_bin    <= '0;
            r_k      <= '0;
            r_d      <= '0;
            r_bcd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin    <= w_bin_load;
                        r_digits <= '0;
                        r_k      <= '0;
                        r_d      <= '0;
                    end
                end
                S_CORR: begin
                    r_digits[4*r_d +: 4] <= w_nib_corr;
                    r_d <= w_last_digit ? '0 : (r_d + DW'(1));
                end
                S_SHIFT: begin
                    r_digits <= w_shifted[TW-1:WIDTH];
                    r_bin    <= w_shifted[WIDTH-1:0];
                    if (w_last_bit) r_bcd <= w_shifted[TW-1:WIDTH];
                    else            r_k   <= r_k + KW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CONVERSOR_SINAL_EN
    // Sign is captured with the operand and published alongside bcd.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) r_sign <= binario[WIDTH-1];
            if (r_state == S_SHIFT && w_last_bit) r_neg <= r_sign;
        end
    end
`endif

endmodule

// File: tb/tb_controlador_double_dabble.sv
// Bench for controlador_double_dabble (8-bit input, 3 digits) against a decimal-arithmetic reference.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Covers reset, back-to-back, ignored starts, reset abort, full sweep and random gaps.
module tb_controlador_double_dabble;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  binario = 8'd0;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic        negativo;

    int n_checks = 0;
    int n_fail   = 0;

    controlador_double_dabble #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .reset(reset), .start(start), .binario(binario),
        .bcd(bcd), .busy(busy), .done(done), .negativo(negativo)
    );

    always #5 clk = ~clk;

    // Reference: interpret the input, take decimal digits with plain arithmetic.
    function automatic int ref_mag(input logic [7:0] v);
`ifdef CONVERSOR_SINAL_EN
        int s = $signed(v);
        return (s < 0) ? -s : s;
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [11:0] ref_bcd(input logic [7:0] v);
        int m = ref_mag(v);
        logic [3:0] h = 4'((m / 100) % 10);
        logic [3:0] t = 4'((m / 10) % 10);
        logic [3:0] u = 4'(m % 10);
        return {h, t, u};
    endfunction

    function automatic logic ref_neg(input logic [7:0] v);
`ifdef CONVERSOR_SINAL_EN
        return v[7];
`else
        return 1'b0 & v[7];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one conversion from IDLE; scrambles binario after capture; bounded wait for done.
    task automatic run_conv(input logic [7:0] v, output logic [11:0] got, output logic gneg,
                            output int lat, output int bcnt, output bit early);
        logic [11:0] prev;
        prev  = bcd;
        start = 1'b1;
        binario = v;
        lat = 0; bcnt = 0; early = 1'b0;
        while (lat < 100) begin
            tick();
            lat++;
            start   = 1'b0;
            binario = 8'($urandom);
            if (busy) bcnt++;
            if (busy && bcd !== prev) early = 1'b1;
            if (done) break;
        end
        got  = bcd;
        gneg = negativo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h want 000", bcd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (negativo !== 1'b0) begin n_fail++; $display("FAIL reset_neg got %b want 0", negativo); end
    endtask

    task automatic test_zero();
        logic [11:0] g; logic gn; int lat, bc; bit early;
        run_conv(8'd0, g, gn, lat, bc, early);
        n_checks++; if (g !== 12'h000) begin n_fail++; $display("FAIL zero_bcd got %h want 000", g); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL zero_latency got %0d want 33", lat); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_in_done got %b want 0", busy); end
        n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 32", bc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'd255, 8'd99, 8'd100};
        logic [11:0] g; logic gn; int lat, bc; bit early;
        for (int i = 0; i < 3; i++) begin
            // In the done cycle: a start here must be ignored, leaving the DUT idle next cycle.
            start = 1'b1; binario = 8'd5;
            tick();
            start = 1'b0;
            n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_fin_start_ignored busy %b done %b want 0 0", busy, done); end
            run_conv(vals[i], g, gn, lat, bc, early);
            n_checks++; if (g !== ref_bcd(vals[i])) begin n_fail++; $display("FAIL b2b_bcd in %0d got %h want %h", vals[i], g, ref_bcd(vals[i])); end
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
            n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL b2b_bcd_hold got changed want held"); end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0; int done_at = -1; logic [11:0] g = 12'hfff;
        start = 1'b1; binario = 8'd42;
        for (int c = 1; c <= 60; c++) begin
            tick();
            start = 1'b0;
            binario = 8'($urandom);
            if (done) begin ndone++; done_at = c; g = bcd; end
            if (c == 5 || c == 20) begin start = 1'b1; binario = 8'd7; end
        end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        n_checks++; if (g !== 12'h042) begin n_fail++; $display("FAIL ignore_bcd got %h want 042", g); end
        n_checks++; if (done_at !== 33) begin n_fail++; $display("FAIL ignore_done_cycle got %0d want 33", done_at); end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        logic [11:0] g; logic gn; int lat, bc; bit early;
        start = 1'b1; binario = 8'd200;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start = 1'b0;
            if (done) ndone++;
            reset = (c == 10);
        end
        reset = 1'b0;
        n_checks++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got %h want 000", bcd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        run_conv(8'd13, g, gn, lat, bc, early);
        n_checks++; if (g !== 12'h013) begin n_fail++; $display("FAIL abort_next_bcd got %h want 013", g); end
        tick();
    endtask

    task automatic test_sweep();
        logic [11:0] g; logic gn; int lat, bc; bit early;
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), g, gn, lat, bc, early);
            n_checks++; if (g !== ref_bcd(8'(v))) begin n_fail++; $display("FAIL sweep_bcd in %0d got %h want %h", v, g, ref_bcd(8'(v))); end
            n_checks++; if (gn !== ref_neg(8'(v))) begin n_fail++; $display("FAIL sweep_neg in %0d got %b want %b", v, gn, ref_neg(8'(v))); end
            n_checks++; if (lat !== 33 || bc !== 32) begin n_fail++; $display("FAIL sweep_timing in %0d lat %0d busy %0d want 33 32", v, lat, bc); end
            tick();
        end
    endtask

    task automatic test_random_gaps();
        logic [11:0] g; logic gn; int lat, bc; bit early; logic [7:0] v;
        for (int i = 0; i < 30; i++) begin
            v = 8'($urandom);
            run_conv(v, g, gn, lat, bc, early);
            n_checks++; if (g !== ref_bcd(v) || gn !== ref_neg(v)) begin n_fail++; $display("FAIL rand_result in %0d got %h/%b want %h/%b", v, g, gn, ref_bcd(v), ref_neg(v)); end
            n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL rand_bcd_hold in %0d got changed want held", v); end
            for (int j = 0; j <= int'($urandom_range(3, 0)); j++) tick();
        end
    endtask

`ifdef CONVERSOR_SINAL_EN
    task automatic test_signed();
        logic [7:0]  vin  [3] = '{8'h80, 8'hFF, 8'd127};
        logic [11:0] vexp [3] = '{12'h128, 12'h001, 12'h127};
        logic        nexp [3] = '{1'b1, 1'b1, 1'b0};
        logic [11:0] g; logic gn; int lat, bc; bit early;
        for (int i = 0; i < 3; i++) begin
            run_conv(vin[i], g, gn, lat, bc, early);
            n_checks++; if (g !== vexp[i]) begin n_fail++; $display("FAIL signed_bcd in %h got %h want %h", vin[i], g, vexp[i]); end
            n_checks++; if (gn !== nexp[i]) begin n_fail++; $display("FAIL signed_neg in %h got %b want %b", vin[i], gn, nexp[i]); end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        tick();
        test_ignore_start();
        test_reset_abort();
        test_sweep();
        test_random_gaps();
`ifdef CONVERSOR_SINAL_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
